// File: rtl/seg_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_ctrl_if
//  Description : Bundle between the MMIO write decoder and the seven-segment
//                scan controller. Carries the display-word write port, the
//                commit/frame pulses and the segment/anode pin drives.
//  Revision    : 1.0 - initial release
// ============================================================================
interface seg_scan_ctrl_if;
    logic        wr_en;
    logic [31:0] wr_data;
    logic [7:0]  wr_mask;
    logic        lz_en;
    logic        wr_ack;
    logic        frame_done;
    logic [6:0]  seg;
    logic [7:0]  an;

    // CPU/decoder side: issues writes, observes pulses and pins
    modport master (
        output wr_en,
        output wr_data,
        output wr_mask,
        output lz_en,
        input  wr_ack,
        input  frame_done,
        input  seg,
        input  an
    );

    // Scan controller side
    modport slave (
        input  wr_en,
        input  wr_data,
        input  wr_mask,
        input  lz_en,
        output wr_ack,
        output frame_done,
        output seg,
        output an
    );
endinterface
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_ctrl
//  Description : Time-multiplexed scan controller for an 8-digit common-anode
//                seven-segment display. A written word waits in pending
//                registers and commits only at a frame boundary, so a frame
//                never mixes old and new digits. Each slot starts with a
//                blanking interval; digits can be masked or suppressed as
//                leading zeros. All pin outputs are registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl #(
    parameter int PRESCALE = 1000,  // clk cycles per digit slot (>= 2)
    parameter int BLANK    = 16     // dark cycles at slot start (< PRESCALE)
) (
    input  wire logic       clk,
    input  wire logic       rst,
    seg_scan_ctrl_if.slave  bus
);

    localparam int                 c_cnt_w   = $clog2(PRESCALE);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(PRESCALE - 1);
    localparam logic [c_cnt_w-1:0] c_blank   = c_cnt_w'(BLANK);

    // Scan position
    logic [c_cnt_w-1:0] r_cnt;
    logic [2:0]         r_d;

    // Pending (written, not yet displayed) word
    logic [31:0]        r_p_data;
    logic [7:0]         r_p_mask;
    logic               r_p_lz;
    logic               r_p_valid;

    // Active (currently displayed) word
    logic [31:0]        r_a_data;
    logic [7:0]         r_a_mask;
    logic               r_a_lz;

    // Registered outputs
    logic [7:0]         r_an;
    logic [6:0]         r_seg;
    logic               r_wr_ack;
    logic               r_frame_done;

    // Combinational helpers
    logic               w_slot_end;
    logic               w_fb;
    logic               w_commit;
    logic [7:0]         w_lz_sup;
    logic [3:0]         w_nib;
    logic               w_vis;
    logic [6:0]         w_hex_seg;
    logic [7:0]         w_an_nxt;
    logic [6:0]         w_seg_nxt;

    assign w_slot_end = (r_cnt == c_cnt_max);
    assign w_fb       = w_slot_end && (r_d == 3'd7);
    // A write landing on the boundary commits at once, even with nothing pending
    assign w_commit   = w_fb && (r_p_valid || bus.wr_en);

    // Prescale counter and digit index; d wraps 7->0 by natural overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_d   <= 3'd0;
        end else if (w_slot_end) begin
            r_cnt <= '0;
            r_d   <= r_d + 3'd1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Pending registers: last write wins, cleared by commit or reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_p_data  <= 32'd0;
            r_p_mask  <= 8'd0;
            r_p_lz    <= 1'b0;
            r_p_valid <= 1'b0;
        end else if (w_commit) begin
            r_p_valid <= 1'b0;
        end else if (bus.wr_en) begin
            r_p_data  <= bus.wr_data;
            r_p_mask  <= bus.wr_mask;
            r_p_lz    <= bus.lz_en;
            r_p_valid <= 1'b1;
        end
    end

    // Active registers: load at frame boundary, same-cycle write bypasses pending
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_data <= 32'd0;
            r_a_mask <= 8'h00;
            r_a_lz   <= 1'b0;
        end else if (w_commit) begin
            if (bus.wr_en) begin
                r_a_data <= bus.wr_data;
                r_a_mask <= bus.wr_mask;
                r_a_lz   <= bus.lz_en;
            end else begin
                r_a_data <= r_p_data;
                r_a_mask <= r_p_mask;
                r_a_lz   <= r_p_lz;
            end
        end
    end

    // Leading-zero suppression: digit k dark when it and all higher nibbles are 0
    generate
        for (genvar k = 0; k < 8; k++) begin : g_lz
            if (k == 0) begin : g_lz_lsd
                assign w_lz_sup[k] = 1'b0;
            end else begin : g_lz_upper
                assign w_lz_sup[k] = r_a_lz && ((r_a_data >> (4 * k)) == 32'd0);
            end
        end
    endgenerate

    assign w_nib = r_a_data[{r_d, 2'b00} +: 4];
    assign w_vis = r_a_mask[r_d] && (r_cnt >= c_blank) && !w_lz_sup[r_d];

    // Hex to active-low segment pattern, bit order gfedcba
    always_comb begin
        w_hex_seg = 7'h7F;
        case (w_nib)
            4'h0:    w_hex_seg = 7'b1000000;
            4'h1:    w_hex_seg = 7'b1111001;
            4'h2:    w_hex_seg = 7'b0100100;
            4'h3:    w_hex_seg = 7'b0110000;
            4'h4:    w_hex_seg = 7'b0011001;
            4'h5:    w_hex_seg = 7'b0010010;
            4'h6:    w_hex_seg = 7'b0000010;
            4'h7:    w_hex_seg = 7'b1111000;
            4'h8:    w_hex_seg = 7'b0000000;
            4'h9:    w_hex_seg = 7'b0010000;
            4'hA:    w_hex_seg = 7'b0001000;
            4'hB:    w_hex_seg = 7'b0000011;
            4'hC:    w_hex_seg = 7'b1000110;
            4'hD:    w_hex_seg = 7'b0100001;
            4'hE:    w_hex_seg = 7'b0000110;
            4'hF:    w_hex_seg = 7'b0001110;
            default: w_hex_seg = 7'h7F;
        endcase
    end

    // Next pin state: one anode low when the current digit is visible
    always_comb begin
        w_an_nxt  = 8'hFF;
        w_seg_nxt = 7'h7F;
        if (w_vis) begin
            w_an_nxt  = ~(8'd1 << r_d);
            w_seg_nxt = w_hex_seg;
        end
    end

    // Output registers: one cycle behind the scan position
    always_ff @(posedge clk) begin
        if (rst) begin
            r_an         <= 8'hFF;
            r_seg        <= 7'h7F;
            r_wr_ack     <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_an         <= w_an_nxt;
            r_seg        <= w_seg_nxt;
            r_wr_ack     <= w_commit;
            r_frame_done <= w_fb;
        end
    end

    assign bus.an         = r_an;
    assign bus.seg        = r_seg;
    assign bus.wr_ack     = r_wr_ack;
    assign bus.frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg_scan_ctrl
//  Description : Directed self-checking bench for seg_scan_ctrl with
//                PRESCALE=8, BLANK=2 (64-cycle frames).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_ctrl;

    localparam int c_ps    = 8;
    localparam int c_blank = 2;
    localparam int c_frame = 8 * c_ps;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;       // bench's own view of the scan position
    int   checks = 0;
    int   failures = 0;

    seg_scan_ctrl_if bus ();

    seg_scan_ctrl #(.PRESCALE(c_ps), .BLANK(c_blank)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // One clock; cyc tracks the cycle index within the scan, 0 = cnt0/d0 of a frame
    task automatic tick();
        @(posedge clk);
        if (rst) cyc = 0;
        else     cyc = cyc + 1;
        #1;
    endtask

    task automatic goto_pos(input int pos);
        while ((cyc % c_frame) != pos) tick();
    endtask

    // Drive a one-cycle write in the current cycle
    task automatic wr_cycle(input logic [31:0] data, input logic [7:0] mask, input logic lz);
        bus.wr_en   = 1'b1;
        bus.wr_data = data;
        bus.wr_mask = mask;
        bus.lz_en   = lz;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    // Observe a frame starting at position 0 for 63 cycles, ending in the FB cycle.
    // on: digits expected lit; segs: expected pattern of each lit digit.
    task automatic scan_frame(input string name, input logic [7:0] on, input logic [7:0][6:0] segs);
        int p, c, d;
        logic [7:0] exp_an;
        logic [6:0] exp_seg;
        for (int i = 0; i < c_frame - 1; i++) begin
            tick();
            p = (cyc - 1) % c_frame;
            c = p % c_ps;
            d = p / c_ps;
            exp_an  = 8'hFF;
            exp_seg = 7'h7F;
            if (c >= c_blank && on[d]) begin
                exp_an  = ~(8'd1 << d);
                exp_seg = segs[d];
            end
            checks++;
            if (bus.an !== exp_an) begin
                failures++;
                $display("FAIL %s an pos=%0d got=%h exp=%h", name, p, bus.an, exp_an);
            end
            checks++;
            if (bus.seg !== exp_seg) begin
                failures++;
                $display("FAIL %s seg pos=%0d got=%b exp=%b", name, p, bus.seg, exp_seg);
            end
            checks++;
            if (bus.wr_ack !== 1'b0 || bus.frame_done !== 1'b0) begin
                failures++;
                $display("FAIL %s pulses pos=%0d got ack=%b fd=%b exp 0/0", name, p, bus.wr_ack, bus.frame_done);
            end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.an !== 8'hFF || bus.seg !== 7'h7F || bus.wr_ack !== 1'b0 || bus.frame_done !== 1'b0) begin
                failures++;
                $display("FAIL reset_outputs got an=%h seg=%h ack=%b fd=%b exp FF/7F/0/0",
                         bus.an, bus.seg, bus.wr_ack, bus.frame_done);
            end
        end
        rst = 1'b0;
        scan_frame("reset_dark", 8'h00, {8{7'h7F}});
    endtask

    task automatic test_basic_scan();
        goto_pos(c_frame - 1);
        wr_cycle(32'h1234ABCD, 8'hFF, 1'b0);
        checks++;
        if (bus.wr_ack !== 1'b1 || bus.frame_done !== 1'b1) begin
            failures++;
            $display("FAIL basic_ack got ack=%b fd=%b exp 1/1", bus.wr_ack, bus.frame_done);
        end
        scan_frame("basic_scan", 8'hFF,
                   {7'h79, 7'h24, 7'h30, 7'h19, 7'h08, 7'h03, 7'h46, 7'h21});
    endtask

    task automatic test_leading_zero();
        wr_cycle(32'h00000050, 8'hFF, 1'b1);
        checks++;
        if (bus.wr_ack !== 1'b1) begin
            failures++;
            $display("FAIL lz1_ack got=%b exp=1", bus.wr_ack);
        end
        scan_frame("lz_on", 8'h03, {{6{7'h7F}}, 7'h12, 7'h40});
        wr_cycle(32'h00000050, 8'hFF, 1'b0);
        checks++;
        if (bus.wr_ack !== 1'b1) begin
            failures++;
            $display("FAIL lz0_ack got=%b exp=1", bus.wr_ack);
        end
        scan_frame("lz_off", 8'hFF, {{6{7'h40}}, 7'h12, 7'h40});
    endtask

    task automatic test_deferred_commit();
        // Boundary with nothing pending: frame_done only
        tick();
        checks++;
        if (bus.frame_done !== 1'b1 || bus.wr_ack !== 1'b0) begin
            failures++;
            $display("FAIL idle_fb got fd=%b ack=%b exp 1/0", bus.frame_done, bus.wr_ack);
        end
        goto_pos(20);
        wr_cycle(32'hFFFFFFFF, 8'hFF, 1'b1);
        tick();
        wr_cycle(32'h00000007, 8'hFF, 1'b1);
        while ((cyc % c_frame) != c_frame - 1) begin
            checks++;
            if (bus.wr_ack !== 1'b0) begin
                failures++;
                $display("FAIL deferred_early_ack pos=%0d got=%b exp=0", cyc % c_frame, bus.wr_ack);
            end
            tick();
        end
        tick();
        checks++;
        if (bus.wr_ack !== 1'b1 || bus.frame_done !== 1'b1) begin
            failures++;
            $display("FAIL deferred_ack got ack=%b fd=%b exp 1/1", bus.wr_ack, bus.frame_done);
        end
        scan_frame("deferred", 8'h01, {{7{7'h7F}}, 7'h78});
    endtask

    task automatic test_mask_bypass();
        goto_pos(30);
        wr_cycle(32'hFFFFFFFF, 8'hFF, 1'b0);
        goto_pos(c_frame - 1);
        wr_cycle(32'h87654321, 8'h0F, 1'b0);
        checks++;
        if (bus.wr_ack !== 1'b1 || bus.frame_done !== 1'b1) begin
            failures++;
            $display("FAIL bypass_ack got ack=%b fd=%b exp 1/1", bus.wr_ack, bus.frame_done);
        end
        scan_frame("mask_bypass", 8'h0F, {{4{7'h7F}}, 7'h19, 7'h30, 7'h24, 7'h79});
    endtask

    task automatic test_reset_mid_frame();
        // Clear the display first, then leave a write pending across reset
        wr_cycle(32'h0, 8'h00, 1'b0);
        goto_pos(10);
        wr_cycle(32'h11111111, 8'hFF, 1'b0);
        goto_pos(30);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (bus.an !== 8'hFF || bus.seg !== 7'h7F || bus.wr_ack !== 1'b0 || bus.frame_done !== 1'b0) begin
            failures++;
            $display("FAIL midreset_outputs got an=%h seg=%h ack=%b fd=%b exp FF/7F/0/0",
                     bus.an, bus.seg, bus.wr_ack, bus.frame_done);
        end
        scan_frame("midreset_dark", 8'h00, {8{7'h7F}});
        // First boundary after reset: no ack for the discarded write
        tick();
        checks++;
        if (bus.frame_done !== 1'b1 || bus.wr_ack !== 1'b0) begin
            failures++;
            $display("FAIL midreset_fb got fd=%b ack=%b exp 1/0", bus.frame_done, bus.wr_ack);
        end
        // Frame alignment restarted at reset: a boundary write commits here
        goto_pos(c_frame - 1);
        wr_cycle(32'h00000009, 8'h01, 1'b0);
        checks++;
        if (bus.wr_ack !== 1'b1 || bus.frame_done !== 1'b1) begin
            failures++;
            $display("FAIL midreset_realign got ack=%b fd=%b exp 1/1", bus.wr_ack, bus.frame_done);
        end
        scan_frame("midreset_after", 8'h01, {{7{7'h7F}}, 7'h10});
    endtask

    initial begin
        bus.wr_en   = 1'b0;
        bus.wr_data = 32'd0;
        bus.wr_mask = 8'd0;
        bus.lz_en   = 1'b0;
        test_reset();
        test_basic_scan();
        test_leading_zero();
        test_deferred_commit();
        test_mask_bypass();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed controller for an 8-digit common-anode seven-segment display. It holds a 32-bit display word loaded by the CPU-side MMIO write port and scans it one hex digit per slot. Each digit gets a blanking interval against ghosting, optional leading-zero suppression and a per-digit enable mask. New words commit only at frame boundaries, so a displayed frame never mixes old and new digits. The block sits between the MMIO bus decoder and the board's segment and anode pins.

## Interface
- PRESCALE, 1000: clk cycles per digit slot; legal range ≥2.
- BLANK, 16: cycles at the start of each slot with all anodes off; must be < PRESCALE.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  one-cycle write strobe; captures wr_data, wr_mask and lz_en into the pending registers.
- wr_data  in  32  display word; digit k shows wr_data[4k+3:4k]; digit 0 is rightmost.
- wr_mask  in  8  per-digit enable; bit k=0 forces digit k blank.
- lz_en  in  1  leading-zero suppression enable.
- wr_ack  out  1  one-cycle pulse when a pending write commits to the active registers.
- frame_done  out  1  one-cycle pulse at the end of each full 8-slot frame.
- seg  out  7  active-low segments; seg[0]=a … seg[6]=g.
- an  out  8  active-low anodes; an[k] drives digit k.

## Operation
- Prescale counter cnt runs 0..PRESCALE-1. Digit index d runs 0..7 and increments when cnt=PRESCALE-1. d wraps 7→0.
- Frame boundary (FB) is the cycle where cnt=PRESCALE-1 and d=7.
- Pending registers: p_data, p_mask, p_lz, p_valid. On wr_en they load from the inputs and set p_valid. A second wr_en before commit overwrites them: last write wins, and only one ack is issued.
- Commit happens on FB when p_valid=1, or when wr_en=1 in the FB cycle. The write-port values bypass into the active registers, with the same-cycle write taking priority. Commit clears p_valid.
- Digit k is visible when all of the following hold:
  - a_mask[k]=1;
  - cnt ≥ BLANK;
  - it is not suppressed as a leading zero.
- Leading-zero suppression applies when a_lz=1. Digit k is suppressed if nibble k and every nibble above it are 0. Digit 0 is never suppressed by leading-zero suppression. a_mask still applies.
- When the digit is visible: an = ~(1<<d), and seg = the hex pattern (active-low, gfedcba):
  - 0→1000000, 1→1111001, 2→0100100, 3→0110000, 4→0011001, 5→0010010, 6→0000010, 7→1111000
  - 8→0000000, 9→0010000, A→0001000, b→0000011, C→1000110, d→0100001, E→0000110, F→0001110
- When the digit is not visible: an=8'hFF and seg=7'h7F.

## Timing
- an, seg, wr_ack and frame_done are registered. Their value in cycle n+1 is a function of cnt, d and the active registers in cycle n. Latency is 1 cycle.
- Frame length is 8·PRESCALE cycles. frame_done is high in the cycle after FB. wr_ack, when a commit occurs, is high in that same cycle.
- The first slot after a commit (d=0) already displays the new word.
- Reset applies at the clock edge with rst=1 and overrides wr_en. Values after reset:
  - cnt=0, d=0;
  - a_data=0, a_mask=8'h00 (display dark until the first commit), a_lz=0;
  - p_valid=0;
  - an=8'hFF, seg=7'h7F, wr_ack=0, frame_done=0.
- Reset mid-frame discards any pending write; no ack is issued for it.
- wr_en in the cycle right after FB is held pending for a full frame (≈8·PRESCALE cycles) before it commits.

## Test plan
Bench parameters: PRESCALE=8, BLANK=2.
- Reset: hold rst 3 cycles → an=FF, seg=7F, wr_ack=0, frame_done=0. After release, an stays FF for a full frame (mask=00).
- Basic scan: write 0x1234ABCD, mask FF, lz 0, in the FB cycle → wr_ack next cycle. Then, per slot:
  - slot 0: an=FE, seg=0100001 (d) during cnt 2..7 (outputs delayed 1 cycle);
  - slot 7: an=7F, seg=1111001 (1);
  - an=FF during the first 2 cycles of every slot.
- Leading zeros: write 0x00000050 with lz 1 → only digits 1 (5) and 0 (0) light. With lz 0 → all 8 light, digits 2..7 showing 1000000.
- Deferred commit: write 0xFFFFFFFF mid-frame, then 0x00000007 two cycles later → exactly one wr_ack, coincident with frame_done. The next frame shows only 7 on digit 0 when lz=1.
- Mask and bypass: wr_en with mask 0x0F in the FB cycle → committed immediately; digits 4..7 blank in the next frame.
- Reset mid-frame: pending write present, rst for 1 cycle → no wr_ack, display dark, cnt/d restart at 0.
